fattree_up_port_selector: RTL and testbench

FATTREE_UP_PORT_SELECTOR -- requirements
Module: fattree_up_port_selector

---
 rtl/fattree_up_port_selector_pkg.sv | 28 ++
 rtl/fattree_upsel_maxcredit.sv | 37 +++
 rtl/fattree_up_port_selector.sv | 131 +++++++++++++
 tb/tb_fattree_up_port_selector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fattree_up_port_selector_pkg.sv
// Shared NoC definitions for the fat-tree up-port selector: policy enum and width helpers.
package fattree_up_port_selector_pkg;

    typedef enum logic {
        DETERMINISTIC = 1'b0,
        ADAPTIVE      = 1'b1
    } mode_e;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int kw_of(input int k);
        return clog2_min1(k);
    endfunction

    function automatic int lw_of(input int l);
        return clog2_min1(l);
    endfunction

    // Counter must hold the full depth value, hence depth+1 codes.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fattree_upsel_maxcredit.sv
// Picks the up port holding the most credits; ties resolve to the first port found scanning from rr_ptr.
module fattree_upsel_maxcredit
    import fattree_up_port_selector_pkg::*;
#(
    parameter int K  = 2,
    parameter int CW = 3
) (
    input  logic [K*CW-1:0]      credit,
    input  logic [kw_of(K)-1:0]  rr_ptr,
    output logic [kw_of(K)-1:0]  sel
);

    localparam int KW = kw_of(K);

    logic [CW-1:0] best_val;
    logic [CW-1:0] cand;
    logic [KW:0]   idx;

    always_comb begin
        sel      = rr_ptr;
        best_val = credit[rr_ptr*CW +: CW];
        idx      = '0;
        cand     = '0;
        // Strict greater-than keeps the earliest port in round-robin order on ties.
        for (int i = 1; i < K; i++) begin
            idx = {1'b0, rr_ptr} + (KW+1)'(i);
            if (idx >= (KW+1)'(K))
                idx = idx - (KW+1)'(K);
            cand = credit[idx*CW +: CW];
            if (cand > best_val) begin
                best_val = cand;
                sel      = idx[KW-1:0];
            end
        end
    end

endmodule

// File: rtl/fattree_up_port_selector.sv
// Fat-tree up-port selector: picks an up port per packet, holds it for the packet, tracks per-port credits.
//   state  | meaning
//   IDLE   | no packet in flight; heads are routed using the current selection
//   LOCKED | multi-flit packet in flight; body/tail flits follow locked_port
module fattree_up_port_selector
    import fattree_up_port_selector_pkg::*;
#(
    parameter int    K          = 2,
    parameter int    L          = 2,
    parameter int    CRED_DEPTH = 4,
    parameter mode_e MODE       = DETERMINISTIC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_hdr,
    input  logic                     in_tail,
    input  logic [L*kw_of(K)-1:0]    in_dest_addr,
    input  logic [lw_of(L)-1:0]      current_layer,
    output logic                     in_ready,
    output logic [K-1:0]             out_wr,
    input  logic [K-1:0]             out_credit_in,
    output logic [kw_of(K)-1:0]      out_port,
    output logic                     busy,
    output logic                     credit_err,
    output logic                     proto_err
);

    localparam int KW = kw_of(K);
    localparam int CW = cw_of(CRED_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(CRED_DEPTH);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e        state;
    logic [KW-1:0] locked_port;
    logic [KW-1:0] rr_ptr;
    logic [CW-1:0] credit [K];

    logic [KW-1:0] digit;
    logic [KW-1:0] sel_det;
    logic [KW-1:0] sel_adapt;
    logic [KW-1:0] sel;
    logic [KW-1:0] tgt;
    logic [K-1:0]  dec_vec;
    logic          accept;
    logic          fwd;
    logic          head_start;

    // Out-of-range digits fold back onto a legal port.
    always_comb begin
        digit = '0;
        if (32'(current_layer) < L)
            digit = in_dest_addr[current_layer*KW +: KW];
        sel_det = (32'(digit) >= K) ? KW'(32'(digit) - K) : digit;
    end

    generate
        if (MODE == ADAPTIVE) begin : g_adaptive
            logic [K*CW-1:0] credit_flat;
            always_comb begin
                credit_flat = '0;
                for (int p = 0; p < K; p++)
                    credit_flat[p*CW +: CW] = credit[p];
            end
            fattree_upsel_maxcredit #(.K(K), .CW(CW)) u_maxcredit (
                .credit (credit_flat),
                .rr_ptr (rr_ptr),
                .sel    (sel_adapt)
            );
        end else begin : g_deterministic
            assign sel_adapt = rr_ptr;
        end
    endgenerate

    assign sel = (MODE == ADAPTIVE) ? sel_adapt : sel_det;

    always_comb begin
        tgt      = (state == LOCKED) ? locked_port : sel;
        in_ready = 1'b1;
        if (state == LOCKED || in_hdr)
            in_ready = (credit[tgt] != '0);
        accept     = in_valid && in_ready;
        fwd        = accept && (state == LOCKED || in_hdr);
        head_start = accept && in_hdr && (state == IDLE);
        dec_vec    = fwd ? (K'(1) << tgt) : '0;
    end

    assign out_port = reset ? '0 : tgt;
    assign busy     = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            locked_port <= '0;
            rr_ptr      <= '0;
            out_wr      <= '0;
            credit_err  <= 1'b0;
            proto_err   <= 1'b0;
            for (int p = 0; p < K; p++)
                credit[p] <= FULL;
        end else begin
            out_wr <= dec_vec;
            for (int p = 0; p < K; p++) begin
                if (dec_vec[p] && !out_credit_in[p])
                    credit[p] <= credit[p] - 1'b1;
                else if (out_credit_in[p] && !dec_vec[p]) begin
                    if (credit[p] == FULL)
                        credit_err <= 1'b1;
                    else
                        credit[p] <= credit[p] + 1'b1;
                end
            end
            // Body outside a packet, or a head inside one, is a protocol violation.
            if (accept && (in_hdr == (state == LOCKED)))
                proto_err <= 1'b1;
            if (state == IDLE) begin
                if (head_start && !in_tail) begin
                    state       <= LOCKED;
                    locked_port <= sel;
                end
            end else begin
                if (accept && in_tail)
                    state <= IDLE;
            end
            if (MODE == ADAPTIVE && head_start)
                rr_ptr <= (32'(sel) == K - 1) ? '0 : sel + 1'b1;
        end
    end

endmodule

// File: tb/tb_fattree_up_port_selector.sv
// Bench for fattree_up_port_selector: directed vector table, hand sequences and a random run against a reference model.
module tb_fattree_up_port_selector;
    import fattree_up_port_selector_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       d_valid, d_hdr, d_tail, d_ready, d_busy, d_cerr, d_perr;
    logic [5:0] d_dest;
    logic [1:0] d_layer, d_port;
    logic [3:0] d_ret, d_wr;
    logic       a_valid, a_hdr, a_tail, a_ready, a_busy, a_cerr, a_perr;
    logic [5:0] a_dest;
    logic [1:0] a_layer, a_port;
    logic [3:0] a_ret, a_wr;

    fattree_up_port_selector #(.K(4), .L(3), .CRED_DEPTH(4), .MODE(DETERMINISTIC)) dut_det (
        .clk(clk), .reset(reset), .in_valid(d_valid), .in_hdr(d_hdr), .in_tail(d_tail),
        .in_dest_addr(d_dest), .current_layer(d_layer), .in_ready(d_ready), .out_wr(d_wr),
        .out_credit_in(d_ret), .out_port(d_port), .busy(d_busy), .credit_err(d_cerr), .proto_err(d_perr)
    );

    fattree_up_port_selector #(.K(4), .L(3), .CRED_DEPTH(4), .MODE(ADAPTIVE)) dut_ada (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_hdr(a_hdr), .in_tail(a_tail),
        .in_dest_addr(a_dest), .current_layer(a_layer), .in_ready(a_ready), .out_wr(a_wr),
        .out_credit_in(a_ret), .out_port(a_port), .busy(a_busy), .credit_err(a_cerr), .proto_err(a_perr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: index 0 = deterministic instance, 1 = adaptive instance.
    int m_cred [2][4];
    bit m_lock [2];
    int m_lport[2];
    int m_rr   [2];
    bit m_perr [2];
    bit m_cerr [2];
    int m_wr   [2];

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) m_cred[d][p] = 4;
            m_lock[d] = 0; m_lport[d] = 0; m_rr[d] = 0;
            m_perr[d] = 0; m_cerr[d] = 0; m_wr[d] = 0;
        end
    endtask

    function automatic int m_sel(input int d, input logic [5:0] dest, input logic [1:0] layer);
        int mx, res;
        bit found;
        if (d == 0) begin
            if (layer < 3) return int'((dest >> (2 * layer)) & 6'h3) % 4;
            return 0;
        end
        mx = 0;
        for (int p = 0; p < 4; p++) if (m_cred[d][p] > mx) mx = m_cred[d][p];
        res = 0; found = 0;
        for (int i = 0; i < 4; i++) begin
            if (!found && m_cred[d][(m_rr[d] + i) % 4] == mx) begin
                res = (m_rr[d] + i) % 4;
                found = 1;
            end
        end
        return res;
    endfunction

    logic       s_ready, s_busy, s_cerr, s_perr;
    logic [1:0] s_port;
    logic [3:0] s_wr;

    // One clock of stimulus to instance d; outputs are checked against the model at the falling edge.
    task automatic step(input int d, input bit rst, input bit v, input bit h, input bit t,
                        input logic [5:0] dest, input logic [1:0] layer, input logic [3:0] ret);
        int sel, tgt, e_port;
        bit e_rdy, acc, fwd;
        reset   = rst;
        d_valid = (d == 0) && v;  a_valid = (d == 1) && v;
        d_ret   = (d == 0) ? ret : 4'b0;  a_ret = (d == 1) ? ret : 4'b0;
        d_hdr = h; d_tail = t; d_dest = dest; d_layer = layer;
        a_hdr = h; a_tail = t; a_dest = dest; a_layer = layer;
        @(negedge clk);
        sel    = m_sel(d, dest, layer);
        tgt    = m_lock[d] ? m_lport[d] : sel;
        e_rdy  = (m_lock[d] || h) ? (m_cred[d][tgt] > 0) : 1'b1;
        e_port = rst ? 0 : tgt;
        if (d == 0) begin
            s_ready = d_ready; s_port = d_port; s_busy = d_busy; s_wr = d_wr; s_cerr = d_cerr; s_perr = d_perr;
        end else begin
            s_ready = a_ready; s_port = a_port; s_busy = a_busy; s_wr = a_wr; s_cerr = a_cerr; s_perr = a_perr;
        end
        chk($sformatf("m%0d in_ready", d), s_ready, e_rdy);
        chk($sformatf("m%0d out_port", d), s_port, e_port);
        chk($sformatf("m%0d busy", d), s_busy, m_lock[d]);
        chk($sformatf("m%0d out_wr", d), s_wr, m_wr[d]);
        chk($sformatf("m%0d credit_err", d), s_cerr, m_cerr[d]);
        chk($sformatf("m%0d proto_err", d), s_perr, m_perr[d]);
        @(posedge clk);
        if (rst) m_reset();
        else begin
            acc = v && e_rdy;
            fwd = acc && (m_lock[d] || h);
            m_wr[1-d] = 0;
            m_wr[d]   = fwd ? (1 << tgt) : 0;
            if (acc && (h == m_lock[d])) m_perr[d] = 1;
            for (int p = 0; p < 4; p++) begin
                m_cred[d][p] += int'(ret[p]) - ((fwd && tgt == p) ? 1 : 0);
                if (m_cred[d][p] > 4) begin m_cred[d][p] = 4; m_cerr[d] = 1; end
            end
            if (!m_lock[d] && acc && h) begin
                if (d == 1) m_rr[d] = (sel + 1) % 4;
                if (!t) begin m_lock[d] = 1; m_lport[d] = sel; end
            end else if (m_lock[d] && acc && t) m_lock[d] = 0;
        end
        #1;
    endtask

    typedef struct {
        bit v, h, t; logic [5:0] dest; logic [3:0] ret;
        bit rdy; int port; bit busy; logic [3:0] wr; bit perr, cerr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit v, bit h, bit t, logic [5:0] dest, logic [3:0] ret,
                                bit rdy, int port, bit busy, logic [3:0] wr, bit perr, bit cerr);
        vec_t r;
        r.v = v; r.h = h; r.t = t; r.dest = dest; r.ret = ret;
        r.rdy = rdy; r.port = port; r.busy = busy; r.wr = wr; r.perr = perr; r.cerr = cerr;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [5:0] D3 = 6'b10_11_01;  // digits {2,3,1}; layer 1 -> port 3
    localparam logic [5:0] Z0 = 6'b00_00_00;
    localparam logic [5:0] P1 = 6'b00_01_00;
    localparam logic [5:0] P2 = 6'b00_10_00;

    initial begin
        int ap[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        int d;
        reset = 1'b1;
        d_valid = 0; d_hdr = 0; d_tail = 0; d_dest = 0; d_layer = 0; d_ret = 0;
        a_valid = 0; a_hdr = 0; a_tail = 0; a_dest = 0; a_layer = 0; a_ret = 0;
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        step(0, 1, 0, 0, 0, Z0, 0, 0);
        chk("reset out_wr", s_wr, 0);
        chk("reset busy", s_busy, 0);
        chk("reset out_port", s_port, 0);

        //            v h t dest ret      rdy port busy wr     perr cerr
        tbl.push_back(mk(1,1,0, D3, 4'b0000, 1, 3, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1,0,0, D3, 4'b0000, 1, 3, 1, 4'b1000, 0, 0));
        tbl.push_back(mk(1,0,1, D3, 4'b0000, 1, 3, 1, 4'b1000, 0, 0));
        tbl.push_back(mk(0,0,0, D3, 4'b0000, 1, 3, 0, 4'b1000, 0, 0));
        tbl.push_back(mk(0,1,0, D3, 4'b0000, 1, 3, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1,1,1, D3, 4'b0000, 1, 3, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1,1,1, D3, 4'b0000, 0, 3, 0, 4'b1000, 0, 0));
        tbl.push_back(mk(0,0,0, D3, 4'b1000, 1, 3, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1,1,1, Z0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1,1,1, Z0, 4'b0000, 1, 0, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(1,1,1, Z0, 4'b0000, 1, 0, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(1,1,1, Z0, 4'b0000, 1, 0, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(1,1,1, Z0, 4'b0001, 0, 0, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(1,1,1, Z0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(0,0,0, Z0, 4'b0000, 1, 0, 0, 4'b0001, 0, 0));
        tbl.push_back(mk(1,0,0, Z0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(0,0,0, Z0, 4'b0010, 1, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0,0,0, Z0, 4'b0000, 1, 0, 0, 4'b0000, 1, 1));
        tbl.push_back(mk(1,1,1, P1, 4'b0000, 1, 1, 0, 4'b0000, 1, 1));
        tbl.push_back(mk(1,1,1, P1, 4'b0000, 1, 1, 0, 4'b0010, 1, 1));
        tbl.push_back(mk(1,1,1, P1, 4'b0000, 1, 1, 0, 4'b0010, 1, 1));
        tbl.push_back(mk(1,1,1, P1, 4'b0000, 1, 1, 0, 4'b0010, 1, 1));
        tbl.push_back(mk(1,1,1, P1, 4'b0000, 0, 1, 0, 4'b0010, 1, 1));
        tbl.push_back(mk(0,0,0, P1, 4'b0010, 1, 1, 0, 4'b0000, 1, 1));

        foreach (tbl[i]) begin
            step(0, 0, tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].dest, 2'd1, tbl[i].ret);
            chk($sformatf("tbl%0d in_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d out_port", i), s_port, tbl[i].port);
            chk($sformatf("tbl%0d busy", i), s_busy, tbl[i].busy);
            chk($sformatf("tbl%0d out_wr", i), s_wr, tbl[i].wr);
            chk($sformatf("tbl%0d proto_err", i), s_perr, tbl[i].perr);
            chk($sformatf("tbl%0d credit_err", i), s_cerr, tbl[i].cerr);
        end

        // Adaptive: ten single-flit heads walk the ports, then credits become {1,3,3,2} with rr_ptr=2.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 1, 1, 6'($urandom), 2'($urandom_range(2)), 4'b0);
            chk($sformatf("ada head%0d port", i), s_port, ap[i]);
            chk($sformatf("ada head%0d ready", i), s_ready, 1);
        end
        step(1, 0, 0, 0, 0, Z0, 0, 4'b0110);
        step(1, 0, 0, 0, 0, Z0, 0, 4'b0010);
        step(1, 0, 0, 1, 0, Z0, 0, 4'b0000);
        chk("ada tie from rr_ptr", s_port, 2);

        // Reset in the middle of a 4-flit packet to port 2.
        step(0, 0, 1, 1, 0, P2, 1, 0);
        step(0, 0, 1, 0, 0, P2, 1, 0);
        step(0, 1, 1, 0, 0, P2, 1, 0);
        chk("rst cycle out_wr", s_wr, 4'b0100);
        step(0, 0, 0, 0, 0, P2, 1, 0);
        chk("post-rst busy", s_busy, 0);
        chk("post-rst out_wr", s_wr, 0);
        chk("post-rst credit_err", s_cerr, 0);
        chk("post-rst proto_err", s_perr, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 1, P2, 1, 0);
            chk($sformatf("post-rst head%0d ready", i), s_ready, (i < 4) ? 1 : 0);
            chk($sformatf("post-rst head%0d port", i), s_port, 2);
        end

        // Random traffic on both instances against the model.
        for (int i = 0; i < 800; i++) begin
            d = int'($urandom_range(1));
            step(d, ($urandom_range(99) == 0),
                 ($urandom_range(3) != 0), ($urandom_range(2) == 0), 1'($urandom),
                 6'($urandom), 2'($urandom_range(2)),
                 {($urandom_range(5) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(5) == 0), ($urandom_range(5) == 0)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
